// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: 2-way set-associative, write-back, write-allocate cache
// controller for single-word lines. Handles one request at a time. Misses
// are serviced against a single-port RAM that has a 1-cycle read latency.
//
// Ports
//   CLOCK_50                 system clock (rising edge)
//   reset                    asynchronous active-low reset
//   req/wr/addr/wdata        request; sampled only while ready=1
//   ready                    idle, a request can be accepted
//   done                     one-cycle completion pulse
//   hit                      hit flag of the last completed request
//   rdata                    read result (for writes, the written word)
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata   backing RAM interface
//   hit_cnt/miss_cnt         saturating statistics (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN
module cache_ctrl_2way #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef CACHE_STATS_EN
    output logic [7:0]        hit_cnt,
    output logic [7:0]        miss_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 2 ** IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, ALLOC, FILL} state_t;

    state_t state, state_n;

    logic [1:0][SETS-1:0]             valid_q, dirty_q;
    logic [1:0][SETS-1:0][TAG_W-1:0]  tag_q;
    logic [1:0][SETS-1:0][DATA_W-1:0] data_q;
    logic [SETS-1:0]                  lru_q;   // way to evict next

    logic              r_wr, r_vic;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic [1:0]       hit_w;
    logic             hit_any, hit_way, vic, vic_dirty;

    assign idx = r_addr[IDX_W-1:0];
    assign tg  = r_addr[ADDR_W-1:IDX_W];

    always_comb begin
        for (int w = 0; w < 2; w++)
            hit_w[w] = valid_q[w][idx] && (tag_q[w][idx] == tg);
        hit_any = |hit_w;
        hit_way = hit_w[1];
        // Fill an empty way before evicting; way0 first.
        if (!valid_q[0][idx])      vic = 1'b0;
        else if (!valid_q[1][idx]) vic = 1'b1;
        else                       vic = lru_q[idx];
        vic_dirty = valid_q[vic][idx] && dirty_q[vic][idx];
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = LOOKUP;
            LOOKUP: begin
                if (hit_any)        state_n = IDLE;
                else if (vic_dirty) state_n = WB;
                else if (r_wr)      state_n = IDLE;
                else                state_n = ALLOC;
            end
            WB:      state_n = r_wr ? IDLE : ALLOC;
            ALLOC:   state_n = FILL;
            FILL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            lru_q     <= '0;
            r_wr      <= 1'b0;
            r_vic     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            hit       <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    r_wr    <= wr;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    ready   <= 1'b0;
                end
                LOOKUP: begin
                    if (hit_any) begin
                        if (r_wr) begin
                            data_q[hit_way][idx]  <= r_wdata;
                            dirty_q[hit_way][idx] <= 1'b1;
                            rdata                 <= r_wdata;
                        end else begin
                            rdata <= data_q[hit_way][idx];
                        end
                        lru_q[idx] <= ~hit_way;
                        hit   <= 1'b1;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        r_vic <= vic;
                        if (vic_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[vic][idx], idx};
                            mem_wdata <= data_q[vic][idx];
                        end else if (r_wr) begin
                            valid_q[vic][idx] <= 1'b1;
                            dirty_q[vic][idx] <= 1'b1;
                            tag_q[vic][idx]   <= tg;
                            data_q[vic][idx]  <= r_wdata;
                            lru_q[idx]        <= ~vic;
                            rdata <= r_wdata;
                            hit   <= 1'b0;
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end else begin
                            mem_re   <= 1'b1;
                            mem_addr <= r_addr;
                        end
                    end
                end
                WB: begin
                    if (r_wr) begin
                        valid_q[r_vic][idx] <= 1'b1;
                        dirty_q[r_vic][idx] <= 1'b1;
                        tag_q[r_vic][idx]   <= tg;
                        data_q[r_vic][idx]  <= r_wdata;
                        lru_q[idx]          <= ~r_vic;
                        rdata <= r_wdata;
                        hit   <= 1'b0;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        mem_re   <= 1'b1;
                        mem_addr <= r_addr;
                    end
                end
                ALLOC: ;  // RAM read in flight; data arrives during FILL
                FILL: begin
                    valid_q[r_vic][idx] <= 1'b1;
                    dirty_q[r_vic][idx] <= 1'b0;
                    tag_q[r_vic][idx]   <= tg;
                    data_q[r_vic][idx]  <= mem_rdata;
                    lru_q[idx]          <= ~r_vic;
                    rdata <= mem_rdata;
                    hit   <= 1'b0;
                    done  <= 1'b1;
                    ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Counts follow the registered done pulse, so they settle one cycle after it.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (done) begin
            if (hit) begin
                if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
            end else begin
                if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
